// File: rtl/mmio_pkg.sv
// +------------------------------------------------------------------+
// | mmio_pkg                                                         |
// | Shared MMIO address map, TCON bit indices and address decoding.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package mmio_pkg;

  localparam logic [3:0]  MMIO_BASE_NIBBLE = 4'h4;

  localparam logic [31:0] ADDR_TH       = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL       = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON     = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED      = 32'h4000_000C;
  localparam logic [31:0] ADDR_DIGI     = 32'h4000_0010;
  localparam logic [31:0] ADDR_SYSTICK  = 32'h4000_0014;
  localparam logic [31:0] ADDR_UART_TX  = 32'h4000_0018;
  localparam logic [31:0] ADDR_UART_RX  = 32'h4000_001C;
  localparam logic [31:0] ADDR_UART_CON = 32'h4000_0020;

  localparam int TCON_EN     = 0;
  localparam int TCON_IRQ_EN = 1;
  localparam int TCON_STATUS = 2;

  typedef enum logic [1:0] {
    REGION_RAM  = 2'd0,
    REGION_MMIO = 2'd1,
    REGION_NONE = 2'd2
  } region_e;

  function automatic region_e decode_region(input logic [31:0] a,
                                            input logic [31:0] depth);
    if (a[31:28] == MMIO_BASE_NIBBLE)
      return REGION_MMIO;
    else if ({2'b00, a[31:2]} < depth)
      return REGION_RAM;
    else
      return REGION_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_timer.sv
// +------------------------------------------------------------------+
// | mmio_timer                                                       |
// | Reloadable up-counting timer (TH/TL/TCON) with interrupt output. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module mmio_timer
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wdata,
  input  logic        th_we,
  input  logic        tl_we,
  input  logic        tcon_we,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic        w_overflow;

  assign w_overflow = r_tcon[TCON_EN] && (r_tl == 32'hFFFF_FFFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      if (th_we)
        r_th <= wdata;

      // A CPU write to TL pre-empts both counting and the overflow event
      if (tl_we)
        r_tl <= wdata;
      else if (r_tcon[TCON_EN])
        r_tl <= w_overflow ? r_th : r_tl + 32'd1;

      if (tcon_we) begin
        r_tcon[TCON_EN]     <= wdata[TCON_EN];
        r_tcon[TCON_IRQ_EN] <= wdata[TCON_IRQ_EN];
      end

      if (w_overflow && !tl_we)
        r_tcon[TCON_STATUS] <= 1'b1;
      else if (tcon_we && wdata[TCON_STATUS])
        r_tcon[TCON_STATUS] <= 1'b0;
    end
  end

  assign th   = r_th;
  assign tl   = r_tl;
  assign tcon = r_tcon;
  assign irq  = r_tcon[TCON_STATUS] & r_tcon[TCON_IRQ_EN];

endmodule

`default_nettype wire

// File: rtl/data_mem_mmio.sv
// +------------------------------------------------------------------+
// | data_mem_mmio                                                    |
// | Byte-enable word RAM plus timer/LED/7-seg/systick/UART MMIO.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module data_mem_mmio
  import mmio_pkg::*;
#(
  parameter int RAM_DEPTH  = 512,
  parameter int RAM_ADDR_W = 9,
  parameter int LED_W      = 8,
  parameter int DIGI_W     = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [3:0]        byte_en,
  output logic [31:0]       rdata,
  output logic [LED_W-1:0]  led,
  output logic [DIGI_W-1:0] digi,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_valid,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_start,
  input  logic              uart_tx_busy,
  output logic              irq
);

  logic [31:0]           r_ram [RAM_DEPTH];
  logic [LED_W-1:0]      r_led;
  logic [DIGI_W-1:0]     r_digi;
  logic [31:0]           r_systick;
  logic [7:0]            r_tx_data;
  logic                  r_tx_start;
  logic [7:0]            r_rx_buf;
  logic                  r_rx_full;
  logic                  r_rx_overrun;

  region_e               w_region;
  logic [RAM_ADDR_W-1:0] w_word;
  logic                  w_ram_we;
  logic                  w_rx_rd;
  logic                  w_con_rd;
  logic                  w_tx_we;
  logic [31:0]           w_th;
  logic [31:0]           w_tl;
  logic [2:0]            w_tcon;
  logic [31:0]           w_rdata;

  assign w_region = decode_region(addr, 32'(RAM_DEPTH));
  assign w_word   = addr[RAM_ADDR_W+1:2];
  assign w_ram_we = mem_write && (w_region == REGION_RAM);
  assign w_tx_we  = mem_write && (addr == ADDR_UART_TX);
  assign w_rx_rd  = mem_read  && (addr == ADDR_UART_RX);
  assign w_con_rd = mem_read  && (addr == ADDR_UART_CON);

  mmio_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wdata   (wdata),
    .th_we   (mem_write && (addr == ADDR_TH)),
    .tl_we   (mem_write && (addr == ADDR_TL)),
    .tcon_we (mem_write && (addr == ADDR_TCON)),
    .th      (w_th),
    .tl      (w_tl),
    .tcon    (w_tcon),
    .irq     (irq)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RAM_DEPTH; i++)
        r_ram[i] <= '0;
    end else if (w_ram_we) begin
      for (int b = 0; b < 4; b++)
        if (byte_en[b])
          r_ram[w_word][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led     <= '0;
      r_digi    <= '0;
      r_systick <= '0;
    end else begin
      r_systick <= r_systick + 32'd1;
      if (mem_write && (addr == ADDR_LED))
        r_led <= wdata[LED_W-1:0];
      if (mem_write && (addr == ADDR_DIGI))
        r_digi <= wdata[DIGI_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_data    <= '0;
      r_tx_start   <= 1'b0;
      r_rx_buf     <= '0;
      r_rx_full    <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      if (w_tx_we && !uart_tx_busy) begin
        r_tx_data  <= wdata[7:0];
        r_tx_start <= 1'b1;
      end

      // A new byte landing during the draining read keeps the mailbox full
      if (uart_rx_valid) begin
        r_rx_buf  <= uart_rx_data;
        r_rx_full <= 1'b1;
      end else if (w_rx_rd) begin
        r_rx_full <= 1'b0;
      end

      if (uart_rx_valid && r_rx_full && !w_rx_rd)
        r_rx_overrun <= 1'b1;
      else if (w_con_rd)
        r_rx_overrun <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (mem_read) begin
      if (w_region == REGION_RAM) begin
        w_rdata = r_ram[w_word];
      end else if (w_region == REGION_MMIO) begin
        case (addr)
          ADDR_TH:       w_rdata = w_th;
          ADDR_TL:       w_rdata = w_tl;
          ADDR_TCON:     w_rdata = {29'd0, w_tcon};
          ADDR_LED:      w_rdata = 32'(r_led);
          ADDR_DIGI:     w_rdata = 32'(r_digi);
          ADDR_SYSTICK:  w_rdata = r_systick;
          ADDR_UART_RX:  w_rdata = {24'd0, r_rx_buf};
          ADDR_UART_CON: w_rdata = {29'd0, r_rx_overrun, r_rx_full, uart_tx_busy};
          default:       w_rdata = '0;
        endcase
      end
    end
  end

  assign rdata         = w_rdata;
  assign led           = r_led;
  assign digi          = r_digi;
  assign uart_tx_data  = r_tx_data;
  assign uart_tx_start = r_tx_start;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_mmio.sv
// +------------------------------------------------------------------+
// | tb_data_mem_mmio                                                 |
// | Directed self-checking bench for data_mem_mmio.                  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_data_mem_mmio;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_DIGI = 32'h4000_0010;
  localparam logic [31:0] A_TICK = 32'h4000_0014;
  localparam logic [31:0] A_TX   = 32'h4000_0018;
  localparam logic [31:0] A_RX   = 32'h4000_001C;
  localparam logic [31:0] A_CON  = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  byte_en;
  logic [31:0] rdata;
  logic [7:0]  led;
  logic [11:0] digi;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_start;
  logic        uart_tx_busy;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] tick_a;
  logic [31:0] tick_b;

  always #5 clk = ~clk;

  data_mem_mmio dut (
    .clk           (clk),
    .reset         (reset),
    .addr          (addr),
    .wdata         (wdata),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .byte_en       (byte_en),
    .rdata         (rdata),
    .led           (led),
    .digi          (digi),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_start (uart_tx_start),
    .uart_tx_busy  (uart_tx_busy),
    .irq           (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Tasks start and end 1 time unit after a rising edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; wdata = d; byte_en = be; mem_write = 1'b1;
    @(posedge clk); #1;
    mem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; mem_read = 1'b1;
    #2 d = rdata;
    @(posedge clk); #1;
    mem_read = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    uart_rx_data = b; uart_rx_valid = 1'b1;
    @(posedge clk); #1;
    uart_rx_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr = '0; wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
    byte_en = '0; uart_rx_data = '0; uart_rx_valid = 1'b0; uart_tx_busy = 1'b0;
    @(posedge clk); #1;
    check("reset_led", 32'(led), 32'h0);
    check("reset_digi", 32'(digi), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_tx_start", 32'(uart_tx_start), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // RAM byte lanes and range limit
    wr(32'h8, 32'h1234_5678, 4'hF);
    wr(32'h8, 32'h00AB_0000, 4'b0100);
    rd_check("ram_sb_merge", 32'h8, 32'h12AB_5678);
    addr = 32'h8; #1;
    check("rdata_idle_zero", rdata, 32'h0);
    wr(32'h800, 32'hDEAD_BEEF, 4'hF);
    rd_check("ram_out_of_range", 32'h800, 32'h0);
    wr(32'h7FC, 32'hCAFE_F00D, 4'hF);
    rd_check("ram_last_word", 32'h7FC, 32'hCAFE_F00D);
    rd_check("mmio_unmapped", 32'h4000_0024, 32'h0);

    rd(A_TICK, tick_a);
    rd(A_TICK, tick_b);
    check("systick_step", tick_b - tick_a, 32'h1);

    // Timer overflow, reload, interrupt and W1C
    wr(A_TH, 32'hFFFF_FFF0, 4'hF);
    wr(A_TL, 32'hFFFF_FFFD, 4'hF);
    wr(A_TCON, 32'h3, 4'hF);
    rd_check("tl_counting", A_TL, 32'hFFFF_FFFD);
    @(posedge clk); @(posedge clk); #1;
    check("timer_irq_set", 32'(irq), 32'h1);
    rd_check("tl_reloaded", A_TL, 32'hFFFF_FFF0);
    rd_check("tcon_status", A_TCON, 32'h7);
    wr(A_TCON, 32'h7, 4'hF);
    check("irq_cleared", 32'(irq), 32'h0);
    rd_check("tcon_after_w1c", A_TCON, 32'h3);
    wr(A_TCON, 32'h0, 4'hF);

    // TL write on the overflow cycle wins over reload
    wr(A_TL, 32'hFFFF_FFFE, 4'hF);
    wr(A_TCON, 32'h1, 4'hF);
    @(posedge clk); #1;
    wr(A_TL, 32'h10, 4'hF);
    rd_check("tl_write_wins", A_TL, 32'h10);
    rd_check("tl_next_cycle", A_TL, 32'h11);
    rd_check("status_not_set", A_TCON, 32'h1);

    // Hardware status set beats a simultaneous W1C
    wr(A_TCON, 32'h0, 4'hF);
    wr(A_TL, 32'hFFFF_FFFE, 4'hF);
    wr(A_TCON, 32'h1, 4'hF);
    @(posedge clk); #1;
    wr(A_TCON, 32'h5, 4'hF);
    rd_check("set_beats_w1c", A_TCON, 32'h5);
    wr(A_TCON, 32'h4, 4'hF);
    rd_check("tcon_cleared", A_TCON, 32'h0);

    // UART transmit
    wr(A_TX, 32'h41, 4'hF);
    check("tx_data", 32'(uart_tx_data), 32'h41);
    check("tx_start_pulse", 32'(uart_tx_start), 32'h1);
    @(posedge clk); #1;
    check("tx_start_single", 32'(uart_tx_start), 32'h0);
    rd_check("tx_reads_zero", A_TX, 32'h0);
    uart_tx_busy = 1'b1;
    wr(A_TX, 32'h99, 4'hF);
    check("tx_busy_no_pulse", 32'(uart_tx_start), 32'h0);
    check("tx_busy_data_kept", 32'(uart_tx_data), 32'h41);
    rd_check("con_busy_flag", A_CON, 32'h1);
    uart_tx_busy = 1'b0;

    // UART receive mailbox
    rx_pulse(8'h55);
    rd_check("con_rx_full", A_CON, 32'h2);
    rd_check("rx_data", A_RX, 32'h55);
    rd_check("con_rx_cleared", A_CON, 32'h0);
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    rd_check("con_overrun", A_CON, 32'h6);
    rd_check("con_overrun_rc", A_CON, 32'h2);
    rd_check("rx_latest", A_RX, 32'h22);
    rd_check("con_empty", A_CON, 32'h0);
    rx_pulse(8'h44);
    addr = A_RX; mem_read = 1'b1; uart_rx_data = 8'h77; uart_rx_valid = 1'b1;
    #2 check("rx_same_cycle_old", rdata, 32'h44);
    @(posedge clk); #1;
    mem_read = 1'b0; uart_rx_valid = 1'b0;
    rd_check("con_same_cycle", A_CON, 32'h2);
    rd_check("rx_same_cycle_new", A_RX, 32'h77);

    // LED / 7-seg
    wr(A_LED, 32'hA5, 4'hF);
    wr(A_DIGI, 32'hFFFF_FFFF, 4'h0);
    check("led_port", 32'(led), 32'hA5);
    check("digi_port", 32'(digi), 32'hFFF);
    rd_check("digi_read", A_DIGI, 32'hFFF);

    // Raise irq, then assert reset in the middle of a pending store
    wr(A_TL, 32'hFFFF_FFFF, 4'hF);
    wr(A_TCON, 32'h3, 4'hF);
    @(posedge clk); #1;
    check("irq_before_reset", 32'(irq), 32'h1);
    addr = 32'h8; wdata = 32'hFFFF_FFFF; byte_en = 4'hF; mem_write = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("async_led", 32'(led), 32'h0);
    check("async_digi", 32'(digi), 32'h0);
    check("async_irq", 32'(irq), 32'h0);
    check("async_tx_data", 32'(uart_tx_data), 32'h0);
    mem_write = 1'b0; mem_read = 1'b1;
    #1 check("async_ram", rdata, 32'h0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    rd_check("ram_after_reset", 32'h8, 32'h0);
    rd_check("ram_last_after_reset", 32'h7FC, 32'h0);
    rd_check("tcon_after_reset", A_TCON, 32'h0);
    rd_check("tl_after_reset", A_TL, 32'h0);
    rd_check("con_after_reset", A_CON, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
